// File: rtl/lightboard_pkg.sv
// ---------------------------------------------------------------------------
// lightboard_pkg
// Shared types and widths for the lightboard datapath blocks.
//   unpack_state_t : state encoding of the packet unpacker FSM
//   ADDR_W         : width of a frame pixel address
//   PIX_W          : width of one pixel value
// ---------------------------------------------------------------------------
package lightboard_pkg;

  localparam int ADDR_W = 24;
  localparam int PIX_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    HDR2,
    PAYLOAD,
    DROP
  } unpack_state_t;

endpackage

// File: rtl/packet_unpacker.sv
// ---------------------------------------------------------------------------
// packet_unpacker
// Splits a gap-free UDP payload byte stream into a one-cycle 24-bit start
// address pulse (first three bytes, big-endian) and a contiguous pixel stream
// (every later byte). Packets with an out-of-frame address or a truncated
// header are dropped. Both outputs are registered with one cycle of latency.
//
// Optional feature macro: PIXEL_LIMIT_EN
//   defined   : at most MAX_PIXELS pixels per packet; excess bytes are
//               suppressed and the packet is counted as dropped.
//   undefined : payload length is unbounded, MAX_PIXELS is unused.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   axiiv/axiid  input byte valid / byte
//   addr_axiov   one-cycle start-address valid pulse
//   addr_axiod   packet start address
//   pixel_axiov  pixel valid
//   pixel_axiod  pixel value
//   pkt_count    accepted packets (wraps)
//   drop_count   dropped packets (wraps)
// ---------------------------------------------------------------------------
module packet_unpacker
  import lightboard_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned MAX_PIXELS   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [7:0]        axiid,
  output logic              addr_axiov,
  output logic [ADDR_W-1:0] addr_axiod,
  output logic              pixel_axiov,
  output logic [PIX_W-1:0]  pixel_axiod,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);

  localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_PIXELS);

  // Elaboration-time sanity checks on the configuration.
  if (FRAME_PIXELS == 0 || FRAME_PIXELS > (1 << ADDR_W))
    $error("packet_unpacker: FRAME_PIXELS out of range");
  if (MAX_PIXELS == 0)
    $error("packet_unpacker: MAX_PIXELS must be non-zero");

  unpack_state_t     state;
  logic [15:0]       addr_hi;   // bytes 0 and 1 of the header
  logic [ADDR_W-1:0] hdr_addr;  // full address as the third byte arrives

  assign hdr_addr = {addr_hi, axiid};

`ifdef PIXEL_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_PIXELS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PIXELS);

  logic [CNT_W-1:0] pix_cnt;
  logic             over;      // at least one byte was suppressed
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // A reset landing mid-packet must not let the tail of that packet be
      // mistaken for a new header, so it parks in DROP until axiiv falls.
      state       <= axiiv ? DROP : IDLE;
      addr_hi     <= '0;
      addr_axiov  <= 1'b0;
      addr_axiod  <= '0;
      pixel_axiov <= 1'b0;
      pixel_axiod <= '0;
      pkt_count   <= '0;
      drop_count  <= '0;
`ifdef PIXEL_LIMIT_EN
      pix_cnt     <= '0;
      over        <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // branch below sees the register values from before this edge.
      addr_axiov  <= 1'b0;
      pixel_axiov <= 1'b0;

      case (state)
        IDLE: begin
          if (axiiv) begin
            addr_hi[15:8] <= axiid;
            state         <= HDR1;
          end
        end

        HDR1: begin
          if (axiiv) begin
            addr_hi[7:0] <= axiid;
            state        <= HDR2;
          end else begin
            drop_count <= drop_count + 16'd1;
            state      <= IDLE;
          end
        end

        HDR2: begin
          if (axiiv) begin
            if (hdr_addr < FRAME_LIM) begin
              addr_axiov <= 1'b1;
              addr_axiod <= hdr_addr;
              state      <= PAYLOAD;
            end else begin
              drop_count <= drop_count + 16'd1;
              state      <= DROP;
            end
`ifdef PIXEL_LIMIT_EN
            pix_cnt <= '0;
            over    <= 1'b0;
`endif
          end else begin
            drop_count <= drop_count + 16'd1;
            state      <= IDLE;
          end
        end

        PAYLOAD: begin
`ifdef PIXEL_LIMIT_EN
          if (axiiv) begin
            if (pix_cnt != MAX_CNT) begin
              pixel_axiov <= 1'b1;
              pixel_axiod <= axiid;
              pix_cnt     <= pix_cnt + 1'b1;
            end else begin
              over <= 1'b1;
            end
          end else begin
            if (over) drop_count <= drop_count + 16'd1;
            else      pkt_count  <= pkt_count + 16'd1;
            state <= IDLE;
          end
`else
          if (axiiv) begin
            pixel_axiov <= 1'b1;
            pixel_axiod <= axiid;
          end else begin
            pkt_count <= pkt_count + 16'd1;
            state     <= IDLE;
          end
`endif
        end

        DROP: begin
          if (!axiiv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_unpacker.sv
// ---------------------------------------------------------------------------
// tb_packet_unpacker
// Builds a whole stimulus schedule up front (directed packets followed by
// randomized ones) and, from the packet-level rules, an expected per-cycle
// output trace. The schedule is then played into the DUT one cycle at a
// time and every output is compared just after each rising edge.
// ---------------------------------------------------------------------------
module tb_packet_unpacker;

  localparam int unsigned FRAME = 76800;
  localparam int unsigned TB_MAX = 4;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [7:0]  axiid;
  logic        addr_axiov;
  logic [23:0] addr_axiod;
  logic        pixel_axiov;
  logic [7:0]  pixel_axiod;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  packet_unpacker #(.FRAME_PIXELS(FRAME), .MAX_PIXELS(TB_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .addr_axiov (addr_axiov),
    .addr_axiod (addr_axiod),
    .pixel_axiov(pixel_axiov),
    .pixel_axiod(pixel_axiod),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

`ifdef PIXEL_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  // Stimulus schedule, one entry per cycle.
  logic        st_v [MAXC];
  logic [7:0]  st_d [MAXC];
  logic        st_r [MAXC];
  // Expected outputs right after the edge that samples cycle c.
  logic        ex_av [MAXC];
  logic [23:0] ex_ad [MAXC];
  logic        ex_pv [MAXC];
  logic [7:0]  ex_pd [MAXC];
  int          inc_pkt  [MAXC];
  int          inc_drop [MAXC];
  logic        clr   [MAXC];
  logic [15:0] ex_pkt  [MAXC];
  logic [15:0] ex_drop [MAXC];

  int n = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic add_idle(input int k, input logic r);
    for (int i = 0; i < k; i++) begin
      st_v[n] = 1'b0;
      st_d[n] = 8'($urandom);
      st_r[n] = r;
      clr[n]  = r;
      n++;
    end
  endtask

  // One packet: its bytes back to back, then 'gap' low cycles. rst_at >= 0
  // asserts reset for one cycle while byte rst_at is on the bus.
  task automatic add_packet(input logic [7:0] b[$], input int gap,
                            input int rst_at);
    int s, len, cut, npix;
    logic [23:0] a;
    s   = n;
    len = b.size();
    for (int k = 0; k < len; k++) begin
      st_v[s+k] = 1'b1;
      st_d[s+k] = b[k];
      st_r[s+k] = 1'b0;
    end
    n = s + len;
    add_idle(gap, 1'b0);
    if (rst_at >= 0) begin
      st_r[s+rst_at] = 1'b1;
      clr[s+rst_at]  = 1'b1;
    end
    cut = (rst_at >= 0) ? rst_at : len;
    if (cut >= 3) begin
      a = {b[0], b[1], b[2]};
      if (int'(a) < int'(FRAME)) begin
        ex_av[s+2] = 1'b1;
        ex_ad[s+2] = a;
        npix = 0;
        for (int k = 3; k < cut; k++) begin
          if (!LIMIT || npix < int'(TB_MAX)) begin
            ex_pv[s+k] = 1'b1;
            ex_pd[s+k] = b[k];
            npix++;
          end
        end
        if (rst_at < 0) begin
          if (LIMIT && (len - 3) > int'(TB_MAX)) inc_drop[s+len]++;
          else                                   inc_pkt[s+len]++;
        end
      end else begin
        inc_drop[s+2]++;
      end
    end else if (rst_at < 0) begin
      inc_drop[s+len]++;
    end
  endtask

  function automatic logic [23:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 24'($urandom_range(0, FRAME - 1));
      1:       return 24'(FRAME - 1);
      2:       return 24'(FRAME + $urandom_range(0, 15));
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0]  q[$];
    logic [23:0] a;
    int len, ra;

    for (int c = 0; c < MAXC; c++) begin
      st_v[c] = 1'b0; st_d[c] = '0; st_r[c] = 1'b0;
      ex_av[c] = 1'b0; ex_ad[c] = '0; ex_pv[c] = 1'b0; ex_pd[c] = '0;
      inc_pkt[c] = 0; inc_drop[c] = 0; clr[c] = 1'b0;
    end

    // Power-on reset with the bus idle.
    add_idle(2, 1'b1);
    add_idle(1, 1'b0);

    // Directed cases.
    q = {8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};  add_packet(q, 1, -1);
    q = {8'h01, 8'h2C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    add_packet(q, 2, -1);
    q = {8'h00, 8'h01};                               add_packet(q, 1, -1);
    q = {8'h00, 8'h02, 8'h00, 8'h5A};                 add_packet(q, 1, -1);
    q = {8'h00, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04};
    add_packet(q, 1, -1);
    q = {8'h00, 8'h00, 8'h30, 8'h05, 8'h06, 8'h07, 8'h08};
    add_packet(q, 2, -1);
    q = {8'h00, 8'h00, 8'h40, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    add_packet(q, 1, 5);
    q = {8'h00, 8'h00, 8'h50, 8'hC1, 8'hC2};          add_packet(q, 1, -1);
    q = {8'h00, 8'h00, 8'h60, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6};
    add_packet(q, 1, -1);
    q = {8'h01, 8'h2B, 8'hFF};                        add_packet(q, 1, -1);
    q = {8'hFF, 8'hFF, 8'hFF, 8'h01};                 add_packet(q, 1, -1);
    q = {8'h7E};                                      add_packet(q, 1, -1);
    q = {8'h00, 8'h00, 8'h70, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
    add_packet(q, 1, -1);

    // Randomized packets.
    for (int p = 0; p < 250; p++) begin
      len = $urandom_range(1, 12);
      a = pick_addr();
      q = {};
      for (int k = 0; k < len; k++) begin
        if (k == 0)      q.push_back(a[23:16]);
        else if (k == 1) q.push_back(a[15:8]);
        else if (k == 2) q.push_back(a[7:0]);
        else             q.push_back(8'($urandom));
      end
      ra = ($urandom_range(0, 15) == 0) ? $urandom_range(0, len - 1) : -1;
      add_packet(q, $urandom_range(1, 3), ra);
    end
    add_idle(2, 1'b0);

    // Counter trace from per-packet increments and reset points.
    begin
      logic [15:0] pk, dr;
      pk = '0; dr = '0;
      for (int c = 0; c < n; c++) begin
        if (clr[c]) begin
          pk = '0; dr = '0;
        end else begin
          pk = pk + 16'(inc_pkt[c]);
          dr = dr + 16'(inc_drop[c]);
        end
        ex_pkt[c]  = pk;
        ex_drop[c] = dr;
      end
    end

    // Play the schedule.
    rst = 1'b1; axiiv = 1'b0; axiid = '0;
    for (int c = 0; c < n; c++) begin
      cyc   = c;
      rst   = st_r[c];
      axiiv = st_v[c];
      axiid = st_d[c];
      @(posedge clk);
      #1;
      check("addr_axiov",  32'(addr_axiov),  32'(ex_av[c]));
      check("pixel_axiov", 32'(pixel_axiov), 32'(ex_pv[c]));
      check("pkt_count",   32'(pkt_count),   32'(ex_pkt[c]));
      check("drop_count",  32'(drop_count),  32'(ex_drop[c]));
      if (ex_av[c] || clr[c]) check("addr_axiod",  32'(addr_axiod),  32'(ex_ad[c]));
      if (ex_pv[c] || clr[c]) check("pixel_axiod", 32'(pixel_axiod), 32'(ex_pd[c]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
